// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
//   - stall bus bit indices and the canned stall patterns built from them
//   - controller state encodings
//   - counter widths and a saturating-increment helper
package pipe_ctrl_pkg;

  localparam int REG_AW  = 5;   // register-file address width
  localparam int STALL_W = 6;   // stall bus; bit 5 is reserved and always 0
  localparam int WAIT_W  = 16;  // MEM wait counter, saturates
  localparam int FL_W    = 4;   // flush counter, holds up to FLUSH_CYCLES-1

  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;

  // Load-use freezes pc and if_id only; id_ex gets a bubble instead.
  localparam logic [STALL_W-1:0] STALL_LU =
    (STALL_W'(1) << STALL_PC) | (STALL_W'(1) << STALL_IF_ID);

  // A data-bus wait freezes every stage up to and including mem_wb.
  localparam logic [STALL_W-1:0] STALL_MEM =
    STALL_LU | (STALL_W'(1) << STALL_ID_EX) |
    (STALL_W'(1) << STALL_EX_MEM) | (STALL_W'(1) << STALL_MEM_WB);

  typedef enum logic [1:0] {
    CTRL_IDLE     = 2'd0,
    CTRL_MEM_WAIT = 2'd1,
    CTRL_FLUSH    = 2'd2
  } ctrl_state_e;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_hazard_det.sv
// Load-use hazard compare: a load in EX writes a register that the
// instruction in ID reads, and the bypass network cannot forward it yet.
// Pure combinational so a second ID slot can instantiate another copy.
//   rs1_re/rs1_addr, rs2_re/rs2_addr : ID source operands
//   ex_load, ex_we, ex_waddr         : EX instruction destination info
//   lu                               : hazard present this cycle
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic              rs1_re,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic              rs2_re,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic              ex_load,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_waddr,
  output logic              lu
);

  logic hit1, hit2;

  assign hit1 = rs1_re & (rs1_addr == ex_waddr);
  assign hit2 = rs2_re & (rs2_addr == ex_waddr);

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign lu = ex_load & ex_we & (|ex_waddr) & (hit1 | hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: per-stage stall and flush control
// for load-use hazards, multi-cycle data-bus waits and EX redirects, plus a
// debug counter of stalled cycles.
//   clk, rst                     : clock, asynchronous active-low reset
//   id_reg1_*/id_reg2_*          : ID source operand reads
//   ex_load/ex_we/ex_waddr       : EX destination info
//   ex_jump/ex_jump_addr         : taken redirect resolved in EX
//   mem_req/mem_ack              : data-bus handshake in MEM
//   stall[5:0]                   : pc, if_id, id_ex, ex_mem, mem_wb, rsvd
//   flush_if_id/flush_id_ex      : bubble insertion
//   jump_flag/jump_addr          : pc redirect
//   timeout_err                  : sticky MEM timeout flag
//   stall_cycles                 : cycles with stall[pc] set, wraps
// Outputs are combinational from state and inputs; they are forced to zero
// while rst is low so a reset never leaks a partial pulse.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMEOUT      = 255,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_reg1_re,
  input  logic [4:0]        id_reg1_raddr,
  input  logic              id_reg2_re,
  input  logic [4:0]        id_reg2_raddr,
  input  logic              ex_load,
  input  logic              ex_we,
  input  logic [4:0]        ex_waddr,
  input  logic              ex_jump,
  input  logic [ADDR_W-1:0] ex_jump_addr,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic [5:0]        stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              jump_flag,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              timeout_err,
  output logic [31:0]       stall_cycles
);

  localparam logic [FL_W-1:0]   FL_RELOAD = FL_W'(FLUSH_CYCLES - 1);
  localparam bit                FL_MULTI  = (FLUSH_CYCLES > 1);
  localparam logic [WAIT_W-1:0] TO_VAL    = WAIT_W'(TIMEOUT);

  ctrl_state_e        state_q, state_d;
  ctrl_state_e        ret_q, ret_d;       // state to resume after a MEM wait
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [FL_W-1:0]    fl_cnt_q, fl_cnt_d;
  logic               terr_q, terr_d;
  logic [31:0]        sc_q, sc_d;

  logic               lu;
  logic               mem_block;
  logic [STALL_W-1:0] stall_c;
  logic               fif_c, fex_c, jf_c;
  logic [ADDR_W-1:0]  ja_c;

  pipe_hazard_det u_hazard (
    .rs1_re   (id_reg1_re),
    .rs1_addr (id_reg1_raddr),
    .rs2_re   (id_reg2_re),
    .rs2_addr (id_reg2_raddr),
    .ex_load  (ex_load),
    .ex_we    (ex_we),
    .ex_waddr (ex_waddr),
    .lu       (lu)
  );

  assign mem_block = mem_req & ~mem_ack;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    wait_cnt_d = wait_cnt_q;
    fl_cnt_d   = fl_cnt_q;
    terr_d     = terr_q;
    stall_c    = '0;
    fif_c      = 1'b0;
    fex_c      = 1'b0;
    jf_c       = 1'b0;
    ja_c       = '0;

    case (state_q)
      CTRL_IDLE, CTRL_FLUSH: begin
        // The wrong-path fetch keeps being squashed for the whole flush window.
        if (state_q == CTRL_FLUSH) fif_c = 1'b1;

        if (mem_block) begin
          // fl_cnt is left untouched so the flush resumes where it stopped.
          stall_c    = STALL_MEM;
          ret_d      = state_q;
          state_d    = CTRL_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else if (ex_jump) begin
          jf_c  = 1'b1;
          ja_c  = ex_jump_addr;
          fif_c = 1'b1;
          fex_c = 1'b1;
          if (FL_MULTI) begin
            state_d  = CTRL_FLUSH;
            fl_cnt_d = FL_RELOAD;
          end else begin
            state_d  = CTRL_IDLE;
          end
        end else if (state_q == CTRL_FLUSH) begin
          // ID holds a wrong-path bubble here, so LU is not considered.
          if (fl_cnt_q <= FL_W'(1)) state_d = CTRL_IDLE;
          else                      fl_cnt_d = fl_cnt_q - 1'b1;
        end else if (lu) begin
          stall_c = STALL_LU;
          fex_c   = 1'b1;
        end
      end

      CTRL_MEM_WAIT: begin
        // EX and ID are frozen; their requests are re-evaluated after release.
        if (mem_ack) begin
          state_d = ret_q;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == TO_VAL)) begin
          terr_d  = 1'b1;
          state_d = ret_q;
        end else begin
          stall_c    = STALL_MEM;
          wait_cnt_d = sat_inc(wait_cnt_q);
        end
      end

      default: state_d = CTRL_IDLE;
    endcase
  end

  assign stall       = rst ? stall_c : '0;
  assign flush_if_id = rst & fif_c;
  assign flush_id_ex = rst & fex_c;
  assign jump_flag   = rst & jf_c;
  assign jump_addr   = rst ? ja_c : '0;
  assign timeout_err = terr_q;
  assign stall_cycles = sc_q;

  assign sc_d = stall[STALL_PC] ? sc_q + 32'd1 : sc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CTRL_IDLE;
      ret_q      <= CTRL_IDLE;
      wait_cnt_q <= '0;
      fl_cnt_q   <= '0;
      terr_q     <= 1'b0;
      sc_q       <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      wait_cnt_q <= wait_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
      terr_q     <= terr_d;
      sc_q       <= sc_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (FLUSH_CYCLES=2, TIMEOUT=4). Each step drives
// one cycle of inputs, pushes the expected outputs to a scoreboard queue, and
// pops/compares at the falling edge. stall_cycles is checked against a
// bench-side running count of expected stalled cycles.
module tb_pipe_ctrl;

  typedef struct packed {
    logic        r1e; logic [4:0] r1a;
    logic        r2e; logic [4:0] r2a;
    logic        ld;  logic       we;  logic [4:0] wa;
    logic        jmp; logic [31:0] ja;
    logic        req; logic       ack;
  } stim_t;

  typedef struct packed {
    logic [5:0]  stall;
    logic        fif;
    logic        fex;
    logic        jf;
    logic [31:0] ja;
    logic        terr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_reg1_re, id_reg2_re, ex_load, ex_we, ex_jump, mem_req, mem_ack;
  logic [4:0]  id_reg1_raddr, id_reg2_raddr, ex_waddr;
  logic [31:0] ex_jump_addr;
  logic [5:0]  stall;
  logic        flush_if_id, flush_id_ex, jump_flag, timeout_err;
  logic [31:0] jump_addr, stall_cycles;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_sc = 0;
  logic exp_terr = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(2), .TIMEOUT(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_reg1_re(id_reg1_re), .id_reg1_raddr(id_reg1_raddr),
    .id_reg2_re(id_reg2_re), .id_reg2_raddr(id_reg2_raddr),
    .ex_load(ex_load), .ex_we(ex_we), .ex_waddr(ex_waddr),
    .ex_jump(ex_jump), .ex_jump_addr(ex_jump_addr),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .jump_flag(jump_flag), .jump_addr(jump_addr),
    .timeout_err(timeout_err), .stall_cycles(stall_cycles)
  );

  function automatic stim_t nop();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t lus(input logic [4:0] wa, input logic r1e, input logic [4:0] r1a,
                                input logic r2e, input logic [4:0] r2a);
    stim_t s = '0;
    s.ld = 1'b1; s.we = 1'b1; s.wa = wa;
    s.r1e = r1e; s.r1a = r1a; s.r2e = r2e; s.r2a = r2a;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input stim_t s, input logic [5:0] es, input logic efi, input logic efx,
                      input logic ejf, input logic [31:0] eja, input string tag);
    exp_t e, got;
    id_reg1_re = s.r1e; id_reg1_raddr = s.r1a;
    id_reg2_re = s.r2e; id_reg2_raddr = s.r2a;
    ex_load = s.ld; ex_we = s.we; ex_waddr = s.wa;
    ex_jump = s.jmp; ex_jump_addr = s.ja;
    mem_req = s.req; mem_ack = s.ack;
    e.stall = es; e.fif = efi; e.fex = efx; e.jf = ejf; e.ja = eja; e.terr = exp_terr;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    chk({tag, ".stall"}, 32'(stall), 32'(got.stall));
    chk({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(got.fif));
    chk({tag, ".flush_id_ex"}, 32'(flush_id_ex), 32'(got.fex));
    chk({tag, ".jump_flag"}, 32'(jump_flag), 32'(got.jf));
    chk({tag, ".jump_addr"}, jump_addr, got.ja);
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(got.terr));
    chk({tag, ".stall_cycles"}, stall_cycles, 32'(exp_sc));
    if (got.stall[0]) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] S0  = 6'b000000;
  localparam logic [5:0] SLU = 6'b000011;
  localparam logic [5:0] SM  = 6'b011111;

  initial begin
    stim_t s;

    // Reset held with a live hazard on the inputs: everything must read 0.
    step(lus(5'd5, 1'b1, 5'd5, 1'b0, 5'd0), S0, 0, 0, 0, 32'h0, "rst");
    rst = 1'b1;

    // Load-use cases
    step(lus(5'd5, 1'b1, 5'd5, 1'b0, 5'd0), SLU, 0, 1, 0, 32'h0, "lu_rs1");
    step(nop(), S0, 0, 0, 0, 32'h0, "lu_gone");
    step(lus(5'd0, 1'b1, 5'd0, 1'b0, 5'd0), S0, 0, 0, 0, 32'h0, "lu_x0");
    step(lus(5'd5, 1'b0, 5'd5, 1'b0, 5'd0), S0, 0, 0, 0, 32'h0, "lu_re0");
    step(lus(5'd7, 1'b0, 5'd0, 1'b1, 5'd7), SLU, 0, 1, 0, 32'h0, "lu_rs2");
    s = lus(5'd7, 1'b1, 5'd7, 1'b0, 5'd0); s.ld = 1'b0;
    step(s, S0, 0, 0, 0, 32'h0, "lu_noload");

    // MEM wait released by ack in the fourth cycle
    s = nop(); s.req = 1'b1;
    step(s, SM, 0, 0, 0, 32'h0, "mem_w1");
    step(s, SM, 0, 0, 0, 32'h0, "mem_w2");
    step(s, SM, 0, 0, 0, 32'h0, "mem_w3");
    s.ack = 1'b1;
    step(s, S0, 0, 0, 0, 32'h0, "mem_ack");
    step(s, S0, 0, 0, 0, 32'h0, "mem_zero");

    // Redirect: flush_if_id for two cycles, flush_id_ex and jump_flag one
    s = nop(); s.jmp = 1'b1; s.ja = 32'h0000_0100;
    step(s, S0, 1, 1, 1, 32'h100, "jmp");
    step(nop(), S0, 1, 0, 0, 32'h0, "jmp_fl");
    step(nop(), S0, 0, 0, 0, 32'h0, "jmp_done");

    // Redirect beats LU; LU suppressed during FLUSH
    s = lus(5'd5, 1'b1, 5'd5, 1'b0, 5'd0); s.jmp = 1'b1; s.ja = 32'h140;
    step(s, S0, 1, 1, 1, 32'h140, "jmp_lu");
    step(lus(5'd5, 1'b1, 5'd5, 1'b0, 5'd0), S0, 1, 0, 0, 32'h0, "fl_lu_sup");
    step(nop(), S0, 0, 0, 0, 32'h0, "jl_done");

    // MEM wait beats redirect and LU; jump ignored in the ack cycle
    s = lus(5'd5, 1'b1, 5'd5, 1'b0, 5'd0); s.jmp = 1'b1; s.ja = 32'h180; s.req = 1'b1;
    step(s, SM, 0, 0, 0, 32'h0, "mem_over_jmp");
    s.ack = 1'b1;
    step(s, S0, 0, 0, 0, 32'h0, "ack_jmp_ign");
    step(nop(), S0, 0, 0, 0, 32'h0, "mj_done");

    // MEM wait entered from FLUSH resumes the remaining flush cycle
    s = nop(); s.jmp = 1'b1; s.ja = 32'h200;
    step(s, S0, 1, 1, 1, 32'h200, "j2");
    s = nop(); s.req = 1'b1;
    step(s, SM, 1, 0, 0, 32'h0, "fl_mem");
    s.ack = 1'b1;
    step(s, S0, 0, 0, 0, 32'h0, "fl_ack");
    step(nop(), S0, 1, 0, 0, 32'h0, "fl_resume");
    step(nop(), S0, 0, 0, 0, 32'h0, "fl_end");

    // New redirect during FLUSH restarts it
    s = nop(); s.jmp = 1'b1; s.ja = 32'h300;
    step(s, S0, 1, 1, 1, 32'h300, "j3");
    s.ja = 32'h304;
    step(s, S0, 1, 1, 1, 32'h304, "j_re");
    step(nop(), S0, 1, 0, 0, 32'h0, "j_re_fl");
    step(nop(), S0, 0, 0, 0, 32'h0, "j_re_end");

    // Timeout: four stalled cycles, released in the fifth, sticky flag after
    s = nop(); s.req = 1'b1;
    step(s, SM, 0, 0, 0, 32'h0, "to_1");
    step(s, SM, 0, 0, 0, 32'h0, "to_2");
    step(s, SM, 0, 0, 0, 32'h0, "to_3");
    step(s, SM, 0, 0, 0, 32'h0, "to_4");
    step(s, S0, 0, 0, 0, 32'h0, "to_rel");
    exp_terr = 1'b1;
    step(nop(), S0, 0, 0, 0, 32'h0, "to_flag");
    step(lus(5'd9, 1'b1, 5'd9, 1'b0, 5'd0), SLU, 0, 1, 0, 32'h0, "lu_after_to");

    // Reset in the middle of a flush: outputs and counters clear at once
    s = nop(); s.jmp = 1'b1; s.ja = 32'h400;
    step(s, S0, 1, 1, 1, 32'h400, "j4");
    rst = 1'b0;
    exp_sc = 0;
    exp_terr = 1'b0;
    s = lus(5'd5, 1'b1, 5'd5, 1'b0, 5'd0); s.jmp = 1'b1; s.ja = 32'h500; s.req = 1'b1;
    step(s, S0, 0, 0, 0, 32'h0, "rst_mid_fl");
    rst = 1'b1;
    step(nop(), S0, 0, 0, 0, 32'h0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
